// File: rtl/divsat_16bit_seq.sv
// divsat_16bit_seq: iterative signed 16-bit divider with saturating result.
// Uses restoring division: one conditional subtract per cycle on a 17-bit partial remainder,
// 16 iterations. It applies signs in a fix-up cycle, then pulses done for one cycle.
// Quotient policy: the result clamps to 0x7FFF / 0x8000 and never wraps.
//
// Optional feature: define DIV_REM_EN to add the o_rem port and the remainder sign correction.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset
//   i_start  request, sampled only while idle
//   i_a      dividend (two's complement), captured on accept
//   i_b      divisor (two's complement), captured on accept
//   o_busy   high from the cycle after accept through the done cycle
//   o_done   one-cycle pulse; results valid here and held afterwards
//   o_quot   saturated quotient, truncated toward zero
//   o_rem    remainder with the sign of the dividend (DIV_REM_EN only)
//   o_dz     divide-by-zero flag for the last operation
//   o_ovfl   quotient saturated (0x8000 / 0xFFFF) for the last operation
module divsat_16bit_seq (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_quot,
`ifdef DIV_REM_EN
    output logic [15:0] o_rem,
`endif
    output logic        o_dz,
    output logic        o_ovfl
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [16:0] r_rem;      // partial remainder magnitude
    logic [15:0] r_quo;      // dividend magnitude shifting out, quotient bits shifting in
    logic [16:0] r_dvsr;     // divisor magnitude (0x08000 for 0x8000)
    logic [4:0]  r_cnt;
    logic        r_a_sign;
    logic        r_b_sign;
    logic        r_dz;       // working flag for the operation in flight

    logic [15:0] r_quot;
    logic        r_dz_out;
    logic        r_ovfl_out;
`ifdef DIV_REM_EN
    logic [15:0] r_rem_out;
`endif

    logic [15:0] w_a_mag;
    logic [15:0] w_b_mag;
    logic        w_b_zero;
    logic [17:0] w_rem_sh;
    logic [17:0] w_trial;
    logic        w_qsign;

    // 16-bit unsigned magnitude is enough: |0x8000| = 0x8000.
    assign w_a_mag  = i_a[15] ? (16'h0000 - i_a) : i_a;
    assign w_b_mag  = i_b[15] ? (16'h0000 - i_b) : i_b;
    assign w_b_zero = (i_b == 16'h0000);

    // Shift {rem, quo} left by one and try to subtract the divisor; bit 17 is the borrow.
    assign w_rem_sh = {r_rem, r_quo[15]};
    assign w_trial  = w_rem_sh - {1'b0, r_dvsr};
    assign w_qsign  = r_a_sign ^ r_b_sign;

    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        unique case (r_state)
            StIdle: begin
                // A zero divisor skips the iterations but still spends one cycle in fix-up.
                if (i_start) w_state_next = w_b_zero ? StFix : StCalc;
            end
            StCalc: begin
                o_busy = 1'b1;
                if (r_cnt == 5'd15) w_state_next = StFix;
            end
            StFix: begin
                o_busy       = 1'b1;
                w_state_next = StDone;
            end
            StDone: begin
                o_busy       = 1'b1;
                o_done       = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvsr     <= '0;
            r_cnt      <= '0;
            r_a_sign   <= 1'b0;
            r_b_sign   <= 1'b0;
            r_dz       <= 1'b0;
            r_quot     <= '0;
            r_dz_out   <= 1'b0;
            r_ovfl_out <= 1'b0;
`ifdef DIV_REM_EN
            r_rem_out  <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_a_sign <= i_a[15];
                        r_b_sign <= i_b[15];
                        r_quo    <= w_a_mag;
                        r_dvsr   <= {1'b0, w_b_mag};
                        r_rem    <= '0;
                        r_cnt    <= '0;
                        r_dz     <= w_b_zero;
                    end
                end
                StCalc: begin
                    if (!w_trial[17]) r_rem <= w_trial[16:0];
                    else              r_rem <= w_rem_sh[16:0];
                    r_quo <= {r_quo[14:0], ~w_trial[17]};
                    r_cnt <= r_cnt + 5'd1;
                end
                StFix: begin
                    r_dz_out   <= r_dz;
                    r_ovfl_out <= 1'b0;
                    if (r_dz) begin
                        // r_quo still holds |A| because no iterations ran.
                        r_quot    <= r_a_sign ? 16'h8000 : 16'h7FFF;
`ifdef DIV_REM_EN
                        r_rem_out <= r_a_sign ? (16'h0000 - r_quo) : r_quo;
`endif
                    end else if (!w_qsign && r_quo[15]) begin
                        // A positive quotient of 0x8000 (only 0x8000 / -1) cannot be represented.
                        r_quot     <= 16'h7FFF;
                        r_ovfl_out <= 1'b1;
`ifdef DIV_REM_EN
                        r_rem_out  <= '0;
`endif
                    end else begin
                        r_quot    <= w_qsign ? (16'h0000 - r_quo) : r_quo;
`ifdef DIV_REM_EN
                        r_rem_out <= r_a_sign ? (16'h0000 - r_rem[15:0]) : r_rem[15:0];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_quot = r_quot;
    assign o_dz   = r_dz_out;
    assign o_ovfl = r_ovfl_out;
`ifdef DIV_REM_EN
    assign o_rem  = r_rem_out;
`endif

endmodule
